// File: rtl/ebpf_shift_exec_stage.sv
// Two-stage execute unit for the eBPF LSH/RSH/ARSH instructions (ALU32 and ALU64 classes).
// S1 holds the decoded operation, S2 holds the shift result; both stages stall together under backpressure.
module ebpf_shift_exec_stage #(
    parameter int DATA_W    = 64,
    parameter int REG_IDX_W = 4
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 flush,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [7:0]           in_opcode,
    input  logic [REG_IDX_W-1:0] in_dst_idx,
    input  logic [DATA_W-1:0]    in_dst_val,
    input  logic [DATA_W-1:0]    in_src_val,
    input  logic [31:0]          in_imm,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [REG_IDX_W-1:0] out_dst_idx,
    output logic [DATA_W-1:0]    out_result,
    output logic                 out_we,
    output logic                 out_err
);

    typedef enum logic [1:0] {
        OP_LSH  = 2'd0,
        OP_RSH  = 2'd1,
        OP_ARSH = 2'd2
    } shift_op_e;

    logic                 s1_valid_q, s1_valid_d;
    shift_op_e            s1_op_q, s1_op_d;
    logic                 s1_is64_q, s1_is64_d;
    logic [5:0]           s1_amt_q, s1_amt_d;
    logic [DATA_W-1:0]    s1_operand_q, s1_operand_d;
    logic [REG_IDX_W-1:0] s1_dst_idx_q, s1_dst_idx_d;
    logic                 s1_err_q, s1_err_d;

    logic                 s2_valid_q, s2_valid_d;
    logic [DATA_W-1:0]    s2_result_q, s2_result_d;
    logic [REG_IDX_W-1:0] s2_dst_idx_q, s2_dst_idx_d;
    logic                 s2_err_q, s2_err_d;

    logic                 s2_load;
    logic                 in_accept;
    logic                 is_alu64;
    logic                 is_alu32;
    logic                 op_legal;
    shift_op_e            dec_op;
    logic [DATA_W-1:0]    src_full;
    logic [DATA_W-1:0]    shift64;
    logic [31:0]          shift32;
    logic [DATA_W-1:0]    shift_result;

    // S1 advances exactly when S2 loads, so a full pipe with out_ready high accepts every cycle.
    assign s2_load   = !s2_valid_q || out_ready;
    assign in_ready  = !s1_valid_q || s2_load;
    assign in_accept = in_valid && in_ready && !flush;

    always_comb begin
        is_alu64 = (in_opcode[2:0] == 3'h7);
        is_alu32 = (in_opcode[2:0] == 3'h4);
        src_full = in_opcode[3] ? in_src_val : {{(DATA_W-32){in_imm[31]}}, in_imm};
        dec_op   = OP_LSH;
        op_legal = 1'b0;
        case (in_opcode[7:4])
            4'h6: begin dec_op = OP_LSH;  op_legal = 1'b1; end
            4'h7: begin dec_op = OP_RSH;  op_legal = 1'b1; end
            4'hC: begin dec_op = OP_ARSH; op_legal = 1'b1; end
            default: begin dec_op = OP_LSH; op_legal = 1'b0; end
        endcase
    end

    always_comb begin
        s1_valid_d   = s1_valid_q;
        s1_op_d      = s1_op_q;
        s1_is64_d    = s1_is64_q;
        s1_amt_d     = s1_amt_q;
        s1_operand_d = s1_operand_q;
        s1_dst_idx_d = s1_dst_idx_q;
        s1_err_d     = s1_err_q;
        if (flush) begin
            s1_valid_d = 1'b0;
        end else if (s2_load) begin
            s1_valid_d = in_accept;
            if (in_accept) begin
                s1_op_d      = dec_op;
                s1_is64_d    = is_alu64;
                s1_amt_d     = is_alu64 ? src_full[5:0] : {1'b0, src_full[4:0]};
                s1_operand_d = in_dst_val;
                s1_dst_idx_d = in_dst_idx;
                s1_err_d     = !(op_legal && (is_alu64 || is_alu32));
            end
        end
    end

    // ALU32 shifts see only the low word; ARSH32 therefore takes its sign from bit 31.
    always_comb begin
        shift64 = '0;
        shift32 = '0;
        case (s1_op_q)
            OP_LSH: begin
                shift64 = s1_operand_q << s1_amt_q;
                shift32 = s1_operand_q[31:0] << s1_amt_q[4:0];
            end
            OP_RSH: begin
                shift64 = s1_operand_q >> s1_amt_q;
                shift32 = s1_operand_q[31:0] >> s1_amt_q[4:0];
            end
            OP_ARSH: begin
                shift64 = $signed(s1_operand_q) >>> s1_amt_q;
                shift32 = $signed(s1_operand_q[31:0]) >>> s1_amt_q[4:0];
            end
            default: begin
                shift64 = '0;
                shift32 = '0;
            end
        endcase
        if (s1_err_q)
            shift_result = '0;
        else if (s1_is64_q)
            shift_result = shift64;
        else
            shift_result = {{(DATA_W-32){1'b0}}, shift32};
    end

    always_comb begin
        s2_valid_d   = s2_valid_q;
        s2_result_d  = s2_result_q;
        s2_dst_idx_d = s2_dst_idx_q;
        s2_err_d     = s2_err_q;
        if (flush) begin
            s2_valid_d = 1'b0;
        end else if (s2_load) begin
            s2_valid_d = s1_valid_q;
            if (s1_valid_q) begin
                s2_result_d  = shift_result;
                s2_dst_idx_d = s1_dst_idx_q;
                s2_err_d     = s1_err_q;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_valid_q   <= 1'b0;
            s1_op_q      <= OP_LSH;
            s1_is64_q    <= 1'b0;
            s1_amt_q     <= '0;
            s1_operand_q <= '0;
            s1_dst_idx_q <= '0;
            s1_err_q     <= 1'b0;
            s2_valid_q   <= 1'b0;
            s2_result_q  <= '0;
            s2_dst_idx_q <= '0;
            s2_err_q     <= 1'b0;
        end else begin
            s1_valid_q   <= s1_valid_d;
            s1_op_q      <= s1_op_d;
            s1_is64_q    <= s1_is64_d;
            s1_amt_q     <= s1_amt_d;
            s1_operand_q <= s1_operand_d;
            s1_dst_idx_q <= s1_dst_idx_d;
            s1_err_q     <= s1_err_d;
            s2_valid_q   <= s2_valid_d;
            s2_result_q  <= s2_result_d;
            s2_dst_idx_q <= s2_dst_idx_d;
            s2_err_q     <= s2_err_d;
        end
    end

    assign out_valid   = s2_valid_q;
    assign out_dst_idx = s2_dst_idx_q;
    assign out_result  = s2_result_q;
    assign out_err     = s2_valid_q && s2_err_q;
    assign out_we      = s2_valid_q && !s2_err_q;

endmodule

// File: tb/tb_ebpf_shift_exec_stage.sv
// Directed self-checking bench for ebpf_shift_exec_stage: vector table for the datapath,
// hand-written sequences for backpressure, flush and mid-stream reset.
module tb_ebpf_shift_exec_stage;

   logic        clock;
   logic        rstN;
   logic        flush;
   logic        inValid;
   logic        inReady;
   logic [7:0]  inOpcode;
   logic [3:0]  inDstIdx;
   logic [63:0] inDstVal;
   logic [63:0] inSrcVal;
   logic [31:0] inImm;
   logic        outValid;
   logic        outReady;
   logic [3:0]  outDstIdx;
   logic [63:0] outResult;
   logic        outWe;
   logic        outErr;

   int testsRun;
   int testsFailed;

   typedef struct {
      logic [7:0]  opcode;
      logic [63:0] dst;
      logic [63:0] src;
      logic [31:0] imm;
      logic [63:0] expResult;
      logic        expErr;
   } vector_t;

   vector_t vectors[14];

   ebpf_shift_exec_stage #(.DATA_W(64), .REG_IDX_W(4)) dut (
      .clk        (clock),
      .rst_n      (rstN),
      .flush      (flush),
      .in_valid   (inValid),
      .in_ready   (inReady),
      .in_opcode  (inOpcode),
      .in_dst_idx (inDstIdx),
      .in_dst_val (inDstVal),
      .in_src_val (inSrcVal),
      .in_imm     (inImm),
      .out_valid  (outValid),
      .out_ready  (outReady),
      .out_dst_idx(outDstIdx),
      .out_result (outResult),
      .out_we     (outWe),
      .out_err    (outErr)
   );

   // Free-running 10 ns clock
   initial begin
      clock = 1'b0;
      forever #5 clock = ~clock;
   end

   // Compare one observed value against the bench's own expectation and count it
   task automatic checkOutput(input string name, input logic [63:0] actual, input logic [63:0] expected);
      testsRun++;
      if (actual !== expected) begin
         testsFailed++;
         $display("[TB] FAIL %s: got %h, expected %h", name, actual, expected);
      end
   endtask

   // Drive one instruction onto the input port
   task automatic applyStimulus(input logic valid, input logic [7:0] opcode, input logic [3:0] dstIdx,
                                input logic [63:0] dst, input logic [63:0] src, input logic [31:0] imm);
      inValid  = valid;
      inOpcode = opcode;
      inDstIdx = dstIdx;
      inDstVal = dst;
      inSrcVal = src;
      inImm    = imm;
   endtask

   task automatic nextCycle();
      @(posedge clock);
      #1;
   endtask

   // Hold up to count LSH64-imm ops (1 << (base+k)) until each is accepted, bounded by a cycle budget
   task automatic sendShiftOps(input int count, input int base);
      int sent;
      sent = 0;
      for (int c = 0; c < 20 && sent < count; c++) begin
         applyStimulus(1'b1, 8'h67, 4'(base + sent), 64'd1, 64'd0, 32'(base + sent));
         @(negedge clock);
         if (inReady) sent++;
         nextCycle();
      end
      applyStimulus(1'b0, 8'h00, 4'd0, 64'd0, 64'd0, 32'd0);
      checkOutput("sendShiftOps accepted", 64'(sent), 64'(count));
   endtask

   initial begin
      int tx;
      int rx;
      int txNext;
      logic [63:0] heldResult;

      testsRun    = 0;
      testsFailed = 0;
      rstN        = 1'b0;
      flush       = 1'b0;
      outReady    = 1'b1;
      applyStimulus(1'b0, 8'h00, 4'd0, 64'd0, 64'd0, 32'd0);

      vectors[0]  = '{8'hC7, 64'h8000_0000_0000_0000, 64'd0,  32'd4,          64'hF800_0000_0000_0000, 1'b0};
      vectors[1]  = '{8'hCC, 64'hFFFF_FFFF_8000_0000, 64'd4,  32'd0,          64'h0000_0000_F800_0000, 1'b0};
      vectors[2]  = '{8'h7C, 64'hFFFF_FFFF_8000_0000, 64'd4,  32'd0,          64'h0000_0000_0800_0000, 1'b0};
      vectors[3]  = '{8'h6F, 64'd1,                   64'd65, 32'd0,          64'd2,                   1'b0};
      vectors[4]  = '{8'h6C, 64'd1,                   64'd33, 32'd0,          64'd2,                   1'b0};
      vectors[5]  = '{8'h77, 64'h8000_0000_0000_0000, 64'd0,  32'hFFFF_FFFF,  64'd1,                   1'b0};
      vectors[6]  = '{8'h84, 64'h1234_5678_9ABC_DEF0, 64'd3,  32'd3,          64'd0,                   1'b1};
      vectors[7]  = '{8'h67, 64'h0000_0000_0000_1234, 64'd0,  32'd8,          64'h0000_0000_0012_3400, 1'b0};
      vectors[8]  = '{8'h64, 64'hFFFF_FFFF_0000_0001, 64'd0,  32'd31,         64'h0000_0000_8000_0000, 1'b0};
      vectors[9]  = '{8'hC4, 64'h0000_0000_7000_0000, 64'd0,  32'd4,          64'h0000_0000_0700_0000, 1'b0};
      vectors[10] = '{8'hCF, 64'h8000_0000_0000_0000, 64'd64, 32'd0,          64'h8000_0000_0000_0000, 1'b0};
      vectors[11] = '{8'h6E, 64'd1,                   64'd1,  32'd0,          64'd0,                   1'b1};
      vectors[12] = '{8'h7F, 64'hFFFF_FFFF_FFFF_FFFF, 64'd60, 32'd0,          64'h0000_0000_0000_000F, 1'b0};
      vectors[13] = '{8'h65, 64'd1,                   64'd0,  32'd1,          64'd0,                   1'b1};

      #12;
      checkOutput("reset out_valid",   64'(outValid),  64'd0);
      checkOutput("reset out_result",  outResult,      64'd0);
      checkOutput("reset out_we",      64'(outWe),     64'd0);
      checkOutput("reset out_err",     64'(outErr),    64'd0);
      checkOutput("reset out_dst_idx", 64'(outDstIdx), 64'd0);
      @(negedge clock);
      rstN = 1'b1;
      nextCycle();
      checkOutput("in_ready after reset", 64'(inReady), 64'd1);

      // Single-issue vectors: accept, bubble, then result valid two cycles after accept
      for (int i = 0; i < 14; i++) begin
         applyStimulus(1'b1, vectors[i].opcode, 4'(i % 11), vectors[i].dst, vectors[i].src, vectors[i].imm);
         @(negedge clock);
         checkOutput($sformatf("vec%0d in_ready", i), 64'(inReady), 64'd1);
         nextCycle();
         applyStimulus(1'b0, 8'h00, 4'd0, 64'd0, 64'd0, 32'd0);
         @(negedge clock);
         checkOutput($sformatf("vec%0d early out_valid", i), 64'(outValid), 64'd0);
         nextCycle();
         @(negedge clock);
         checkOutput($sformatf("vec%0d out_valid", i),   64'(outValid),  64'd1);
         checkOutput($sformatf("vec%0d out_result", i),  outResult,      vectors[i].expResult);
         checkOutput($sformatf("vec%0d out_err", i),     64'(outErr),    64'(vectors[i].expErr));
         checkOutput($sformatf("vec%0d out_we", i),      64'(outWe),     64'(!vectors[i].expErr));
         checkOutput($sformatf("vec%0d out_dst_idx", i), 64'(outDstIdx), 64'(i % 11));
         nextCycle();
      end

      // Backpressure: four queued ops, only two fit while out_ready is low
      outReady = 1'b0;
      tx = 0;
      heldResult = '0;
      for (int c = 0; c < 6; c++) begin
         applyStimulus(tx < 4, 8'h67, 4'(tx + 1), 64'd1, 64'd0, 32'(tx + 1));
         @(negedge clock);
         txNext = (inValid && inReady) ? tx + 1 : tx;
         if (c >= 2) checkOutput($sformatf("stall c%0d in_ready", c), 64'(inReady), 64'd0);
         if (c == 2) heldResult = outResult;
         if (c >= 2) begin
            checkOutput($sformatf("stall c%0d out_valid", c), 64'(outValid), 64'd1);
            checkOutput($sformatf("stall c%0d out_result", c), outResult, 64'd2);
            checkOutput($sformatf("stall c%0d held", c), outResult, heldResult);
         end
         nextCycle();
         tx = txNext;
      end
      checkOutput("stall accepted count", 64'(tx), 64'd2);

      outReady = 1'b1;
      rx = 0;
      for (int c = 0; c < 20 && rx < 4; c++) begin
         applyStimulus(tx < 4, 8'h67, 4'(tx + 1), 64'd1, 64'd0, 32'(tx + 1));
         @(negedge clock);
         txNext = (inValid && inReady) ? tx + 1 : tx;
         if (outValid) begin
            checkOutput($sformatf("drain%0d out_result", rx),  outResult,      64'd2 << rx);
            checkOutput($sformatf("drain%0d out_dst_idx", rx), 64'(outDstIdx), 64'(rx + 1));
            rx++;
         end
         nextCycle();
         tx = txNext;
      end
      applyStimulus(1'b0, 8'h00, 4'd0, 64'd0, 64'd0, 32'd0);
      checkOutput("drain received count", 64'(rx), 64'd4);
      repeat (2) begin
         @(negedge clock);
         checkOutput("no duplicate out_valid", 64'(outValid), 64'd0);
         nextCycle();
      end

      // Flush with two ops in flight; the op presented alongside flush must vanish too
      outReady = 1'b0;
      sendShiftOps(2, 1);
      applyStimulus(1'b1, 8'h67, 4'd9, 64'd1, 64'd0, 32'd9);
      flush = 1'b1;
      nextCycle();
      flush = 1'b0;
      applyStimulus(1'b0, 8'h00, 4'd0, 64'd0, 64'd0, 32'd0);
      @(negedge clock);
      checkOutput("flush out_valid", 64'(outValid), 64'd0);
      checkOutput("flush in_ready",  64'(inReady),  64'd1);
      checkOutput("flush out_we",    64'(outWe),    64'd0);
      outReady = 1'b1;
      nextCycle();
      repeat (3) begin
         @(negedge clock);
         checkOutput("post-flush out_valid", 64'(outValid), 64'd0);
         nextCycle();
      end

      // Asynchronous reset with a full, stalled pipe
      outReady = 1'b0;
      sendShiftOps(2, 3);
      @(negedge clock);
      checkOutput("pre-reset out_valid",  64'(outValid), 64'd1);
      checkOutput("pre-reset out_result", outResult,     64'd8);
      #2;
      rstN = 1'b0;
      #1;
      checkOutput("async reset out_valid",   64'(outValid),  64'd0);
      checkOutput("async reset out_result",  outResult,      64'd0);
      checkOutput("async reset out_dst_idx", 64'(outDstIdx), 64'd0);
      checkOutput("async reset out_we",      64'(outWe),     64'd0);
      checkOutput("async reset out_err",     64'(outErr),    64'd0);
      @(negedge clock);
      rstN = 1'b1;
      outReady = 1'b1;
      repeat (3) begin
         nextCycle();
         checkOutput("post-reset out_valid", 64'(outValid), 64'd0);
         checkOutput("post-reset in_ready",  64'(inReady),  64'd1);
      end

      $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
      $finish;
   end

   // Guard against a hung run
   initial begin
      #200000;
      $display("[TB] FAIL timeout: simulation did not finish, expected completion");
      $fatal(1, "[TB] timeout");
   end

endmodule

// File: doc/ebpf_shift_exec_stage.md
Name: ebpf_shift_exec_stage

Overview:
Pipelined execute stage for the eBPF shift class (LSH, RSH, ARSH) in the soft eBPF core. It sits between instruction decode/operand fetch and register-file writeback. It decodes the shift opcode and selects the register or immediate source. It masks the shift amount per eBPF semantics, drives the 64-bit logical and arithmetic shift datapath, and registers results behind a valid/ready handshake with full backpressure.

Parameters:
DATA_W, 64, operand/result width (only 64 supported)
REG_IDX_W, 4, destination register index width (r0-r10)

Ports:
clk  input  1  core clock
rst_n  input  1  asynchronous active-low reset
flush  input  1  synchronous pipeline kill (branch redirect/abort)
in_valid  input  1  upstream instruction valid
in_ready  output  1  stage can accept instruction this cycle
in_opcode  input  8  eBPF opcode byte
in_dst_idx  input  REG_IDX_W  destination register index
in_dst_val  input  64  value of dst register (shift operand)
in_src_val  input  64  value of src register
in_imm  input  32  instruction immediate
out_valid  output  1  result valid
out_ready  input  1  writeback accepts result
out_dst_idx  output  REG_IDX_W  destination index
out_result  output  64  shifted result
out_we  output  1  register write enable (valid, legal op)
out_err  output  1  illegal opcode flag (qualifies with out_valid)

Behaviour:
- Clock domain: one clock, clk. Reset is asynchronous, active-low (rst_n); all flops clear on assertion, release synchronous to clk.
- Reset values: in_ready=1 once out of reset, out_valid=0, out_we=0, out_err=0, out_result=0, out_dst_idx=0, internal stage valids=0.
- Decode: class=opcode[2:0]. 0x4=ALU32, 0x7=ALU64. Source bit opcode[3]: 1=src reg, 0=imm. Op=opcode[7:4]: 0x6 LSH, 0x7 RSH, 0xC ARSH.
- Any other class/op: illegal. The instruction still flows through: out_err=1, out_we=0, out_result=0.
- Source: imm is sign-extended 32->64 before use.
- Amount mask: ALU64 uses src[5:0]. ALU32 uses src[4:0].
- ALU64: result = dst<<amt, dst>>amt, or signed dst>>>amt.
- ALU32: operate on dst[31:0] only. ARSH sign bit is dst[31]. Result zero-extended to 64 (upper 32 bits = 0).
- Pipeline, two register stages:
  - S1 latches decoded op, masked amount, operand, dst idx and err.
  - S2 latches the shift result.
  - Latency: 2 cycles from in_valid&in_ready to out_valid when unstalled. Throughput 1/cycle.
- Handshake:
  - Input transfer on in_valid&in_ready.
  - Output transfer on out_valid&out_ready.
  - S2 loads when S2 is empty or transferring. S1 advances when S2 loads.
  - in_ready = !s1_valid || s1_advance (combinational from out_ready; no bubble on a full pipe).
  - Outputs hold stable while out_valid&!out_ready.
- Backpressure: with out_ready=0, at most 2 instructions are held. in_ready drops the cycle after the second accept.
- flush: clears s1_valid and s2_valid next edge. in_ready=1 after flush. Inputs presented the same cycle as flush are discarded.
- flush simultaneous with an output transfer: the transfer counts (writeback sees it); the stage still empties.
- Reset mid-operation: in-flight instructions are dropped with no partial output.
- out_we = out_valid & !out_err.

Test Plan:
- ALU64 ARSH imm (opcode 0xC7): dst=0x8000_0000_0000_0000, imm=4 -> out_result=0xF800_0000_0000_0000, out_we=1, 2 cycles after accept.
- ALU32 ARSH reg (0xCC): dst=0xFFFF_FFFF_8000_0000, src=4 -> 0x0000_0000_F800_0000. ALU32 RSH (0x7C) same operands -> 0x0000_0000_0800_0000.
- Amount masking: LSH64 reg (0x6F) dst=1, src=65 -> 2. LSH32 reg (0x6C) dst=1, src=33 -> 2. RSH64 imm (0x77) dst=0x8000_0000_0000_0000, imm=0xFFFF_FFFF -> 1.
- Backpressure: stream 4 back-to-back ops with out_ready=0 -> 2 accepted, in_ready=0 from the cycle after the second accept. Raise out_ready -> all 4 results in order, no loss or duplication, outputs stable while stalled.
- Illegal opcode 0x84 -> out_valid=1, out_err=1, out_we=0, out_result=0. Following legal op is unaffected.
- flush with 2 ops in flight and out_ready=0 -> out_valid=0 next cycle, in_ready=1, no writeback. Assert rst_n=0 mid-stream -> all outputs return to reset values immediately.
